// File: rtl/cover_pkg.sv
// cover_pkg: shared types and elaboration helpers for the cover scanner.
//   state_t   - scanner FSM states
//   depth_ok  - elaboration-time legality check on the table depth
package cover_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  localparam int MIN_DEPTH = 2;

  function automatic bit depth_ok(input int d);
    return d >= MIN_DEPTH;
  endfunction

endpackage

// File: rtl/cover_match.sv
// cover_match: combinational cover test of one query against one mask.
//   q, mask  - query word and stored mask (WIDTH bits)
//   valid    - entry valid bit
//   covered  - valid and every 1 in q is also a 1 in mask
//   overlap  - q & mask when covered, else 0
module cover_match #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] mask,
  input  logic             valid,
  output logic             covered,
  output logic [WIDTH-1:0] overlap
);

  assign covered = valid && ((q & ~mask) == '0);
  assign overlap = covered ? (q & mask) : '0;

endmodule

// File: rtl/cover_scanner.sv
// cover_scanner: DEPTH-entry mask table scanned one entry per cycle for the
// first valid mask that covers the query word.
//   clk, rst_n            - clock, async active-low reset
//   wr_en/wr_addr/wr_mask - table write (sets the entry valid bit)
//   clr                   - clears all valid bits, masks kept
//   q_valid/q_ready/q_data- query handshake
//   r_valid/r_ready       - response handshake
//   r_hit/r_index/r_overlap - result, held through RESP
//   busy                  - high in SCAN or RESP
module cover_scanner
  import cover_pkg::*;
#(
  parameter  int WIDTH = 6,
  parameter  int DEPTH = 8,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic             clr,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [WIDTH-1:0] q_data,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             r_hit,
  output logic [IDXW-1:0]  r_index,
  output logic [WIDTH-1:0] r_overlap,
  output logic             busy
);

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("cover_scanner: DEPTH must be >= 2");
  end

  localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);

  state_t           r_state, w_next;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_q;
  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_mask [DEPTH];
  logic             w_cov;
  logic [WIDTH-1:0] w_ov;
  logic             w_wr_ok;
  logic             w_done;

  // Addresses beyond the table (possible when DEPTH is not a power of two)
  // are dropped.
  assign w_wr_ok = wr_en && (int'(wr_addr) < DEPTH);

  cover_match #(.WIDTH(WIDTH)) u_match (
    .q       (r_q),
    .mask    (r_mask[r_idx]),
    .valid   (r_vld[r_idx]),
    .covered (w_cov),
    .overlap (w_ov)
  );

  assign w_done = w_cov || (r_idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    q_ready = 1'b0;
    r_valid = 1'b0;
    busy    = 1'b0;
    case (r_state)
      IDLE: begin
        q_ready = 1'b1;
        if (q_valid) w_next = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (w_done) w_next = RESP;
      end
      RESP: begin
        busy    = 1'b1;
        r_valid = 1'b1;
        if (r_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Query latch, scan index and result registers. The query is sampled only
  // on accept; idx stops at the last entry, never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= '0;
      r_idx     <= '0;
      r_hit     <= 1'b0;
      r_index   <= '0;
      r_overlap <= '0;
    end else if (r_state == IDLE && q_valid) begin
      r_q   <= q_data;
      r_idx <= '0;
    end else if (r_state == SCAN) begin
      if (w_done) begin
        r_hit     <= w_cov;
        r_index   <= w_cov ? r_idx : '0;
        r_overlap <= w_ov;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // clr first, then the write, so a same-cycle write survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      if (clr)     r_vld          <= '0;
      if (w_wr_ok) r_vld[wr_addr] <= 1'b1;
    end
  end

  // Mask storage carries no reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mask[wr_addr] <= wr_mask;
  end

endmodule

// File: tb/tb_cover_scanner.sv
module tb_cover_scanner;

  localparam int WIDTH = 6;
  localparam int DEPTH = 8;
  localparam int IDXW  = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [IDXW-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_mask;
  logic             clr;
  logic             q_valid;
  logic             q_ready;
  logic [WIDTH-1:0] q_data;
  logic             r_valid;
  logic             r_ready;
  logic             r_hit;
  logic [IDXW-1:0]  r_index;
  logic [WIDTH-1:0] r_overlap;
  logic             busy;

  int n_tot = 0;
  int n_bad = 0;

  cover_scanner #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_mask   (wr_mask),
    .clr       (clr),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .q_data    (q_data),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_hit     (r_hit),
    .r_index   (r_index),
    .r_overlap (r_overlap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic en, input int a, input logic [WIDTH-1:0] m, input logic c);
    wr_en   = en;
    wr_addr = IDXW'(a);
    wr_mask = m;
    clr     = c;
    step();
    wr_en = 1'b0;
    clr   = 1'b0;
  endtask

  // Offer a query, count edges after accept until r_valid, check the result,
  // hold r_ready low for `hold` cycles, then release. clr_at>=0 pulses clr
  // while idx==clr_at.
  task automatic do_query(input string tag, input logic [WIDTH-1:0] d,
                          input logic ehit, input int eidx,
                          input logic [WIDTH-1:0] eov, input int elat,
                          input int hold, input int clr_at);
    int lat;
    chk({tag, ".qrdy"}, 32'(q_ready), 32'd1);
    q_valid = 1'b1;
    q_data  = d;
    step();
    q_valid = 1'b0;
    q_data  = '0;
    lat = 0;
    while (!r_valid && lat < 40) begin
      clr = (lat == clr_at);
      step();
      lat++;
    end
    clr = 1'b0;
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    chk({tag, ".hit"}, 32'(r_hit), 32'(ehit));
    chk({tag, ".idx"}, 32'(r_index), 32'(eidx));
    chk({tag, ".ov"},  32'(r_overlap), 32'(eov));
    for (int k = 0; k < hold; k++) begin
      step();
      chk({tag, ".bp_vld"}, 32'(r_valid), 32'd1);
      chk({tag, ".bp_qrdy"}, 32'(q_ready), 32'd0);
      chk({tag, ".bp_idx"}, 32'(r_index), 32'(eidx));
      chk({tag, ".bp_ov"}, 32'(r_overlap), 32'(eov));
    end
    // a query offered in the release cycle must not be taken
    r_ready = 1'b1;
    q_valid = 1'b1;
    q_data  = '1;
    step();
    r_ready = 1'b0;
    q_valid = 1'b0;
    q_data  = '0;
    chk({tag, ".rel_vld"}, 32'(r_valid), 32'd0);
    chk({tag, ".rel_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; clr = 1'b0;
    q_valid = 1'b0; q_data = '0; r_ready = 1'b0;
    #12;
    chk("rst.qrdy", 32'(q_ready), 32'd1);
    chk("rst.rvld", 32'(r_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.idx",  32'(r_index), 32'd0);
    chk("rst.ov",   32'(r_overlap), 32'd0);
    chk("rst.hit",  32'(r_hit), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    do_query("empty", 6'b000000, 1'b0, 0, 6'b000000, 8, 0, -1);

    wr(1'b1, 2, 6'b110111, 1'b0);
    wr(1'b1, 5, 6'b111111, 1'b0);
    do_query("hit5", 6'b111010, 1'b1, 5, 6'b111010, 6, 0, -1);
    do_query("hit2_bp", 6'b110000, 1'b1, 2, 6'b110000, 3, 3, -1);

    // reset at idx==3 while entry5 would hit; previous result was a hit on 2
    q_valid = 1'b1;
    q_data  = 6'b111010;
    step();
    q_valid = 1'b0;
    step(); step(); step();
    chk("mrst.busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst.hit",  32'(r_hit), 32'd0);
    chk("mrst.idx",  32'(r_index), 32'd0);
    chk("mrst.ov",   32'(r_overlap), 32'd0);
    chk("mrst.rvld", 32'(r_valid), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.qrdy", 32'(q_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    do_query("mrst_vclr", 6'b000000, 1'b0, 0, 6'b000000, 8, 0, -1);

    wr(1'b1, 5, 6'b111111, 1'b0);
    do_query("midclr", 6'b111010, 1'b0, 0, 6'b000000, 8, 0, 1);

    wr(1'b0, 0, 6'b000000, 1'b1);
    wr(1'b1, 2, 6'b100100, 1'b0);
    do_query("miss", 6'b000010, 1'b0, 0, 6'b000000, 8, 0, -1);

    wr(1'b1, 6, 6'b111111, 1'b0);
    wr(1'b1, 3, 6'b001000, 1'b1);
    do_query("clrwr_hit", 6'b001000, 1'b1, 3, 6'b001000, 4, 0, -1);
    do_query("clrwr_miss", 6'b010000, 1'b0, 0, 6'b000000, 8, 0, -1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
